alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multicycle issue controller driving the 16-bit `alu` from the initiator side of its `alu_a`/`alu_b`/`alu_ctrl` → `alu_out`/`zero` interface. It accepts one 16-bit instruction per valid/ready handshake and reads operands from the external register file. It presents the operation to the ALU, samples the result, then issues a register writeback or a branch/jump redirect. It sits between fetch and the register file.

## Interface
- No parameters; all widths fixed (16-bit data, 3-bit register index, 4-bit ALU control).
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `instr_valid`  in  1  instruction offered.
- `instr`  in  16  instruction word.
- `pc`  in  16  address of the offered instruction; sampled with `instr`.
- `instr_ready`  out  1  high only in IDLE.
- `rf_ra1` / `rf_ra2`  out  3  register-file read addresses.
- `rf_rd1` / `rf_rd2`  in  16  combinational read data for `rf_ra1`/`rf_ra2`.
- `alu_a` / `alu_b`  out  16  ALU operands (registered).
- `alu_ctrl`  out  4  ALU operation (registered).
- `alu_out`  in  16  ALU result.
- `alu_zero`  in  1  ALU branch flag.
- `rf_we`  out  1  one-cycle write strobe.
- `rf_wa`  out  3  write address.
- `rf_wd`  out  16  write data.
- `br_taken`  out  1  one-cycle redirect strobe.
- `br_target`  out  16  redirect address, valid with `br_taken`.
- `illegal`  out  1  one-cycle strobe for opcodes 0xE/0xF.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Fields: `op`=[15:12], `rd`=[11:9], `rs`=[8:6], `rt`=[5:3], `imm6`=[5:0] sign-extended, `imm12`=[11:0] zero-extended.
- Op 0x0–0x9 (ADD, SUB, ASR, LSR, LSL, AND, OR, SLT, INV, MOV):
  - `alu_ctrl`=op, `alu_a`=R[rs], `alu_b`=R[rt].
  - Writeback `rd`←`alu_out`.
- Op 0xA JUMP:
  - `alu_ctrl`=4'hA, `alu_a`=pc, `alu_b`=imm12.
  - `br_target`=`alu_out`; `br_taken`=1.
- Op 0xB BEQ / 0xC BNE:
  - `rf_ra1`=[11:9], `rf_ra2`=[8:6], `alu_ctrl`=op.
  - `br_taken`=sampled `alu_zero`.
  - `br_target`=pc+1+sext(imm6), computed locally, modulo 2^16.
- Op 0xD ADDI: `alu_ctrl`=4'h0, `alu_a`=R[rs], `alu_b`=sext(imm6); writeback `rd`.
- Op 0xE/0xF: no ALU op, no writeback, no redirect; `illegal` pulses.
- `alu_ctrl` is 4'hF and `alu_a`/`alu_b` are 0 in every state except EXEC. The ALU's default op clears `zero` before each operation, so a not-taken BEQ/BNE never sees a stale flag.
- FSM:
  - IDLE → READ on `instr_valid`&`instr_ready`; captures `instr` and `pc`.
  - READ → EXEC unconditionally; drives `rf_ra1`/`rf_ra2` and loads `alu_a`/`alu_b`/`alu_ctrl` at the edge.
  - EXEC → WB; samples `alu_out` and `alu_zero` into the result registers at the edge.
  - WB → IDLE; `rf_we`, `br_taken` or `illegal` is high for this cycle only.
- Illegal ops also traverse READ/EXEC/WB, with ALU inputs held at default.
- Reset (any state, asynchronous):
  - State → IDLE; all outputs → 0 except `alu_ctrl`=4'hF and `instr_ready`=1.
  - A pending writeback or redirect is discarded.

## Timing
- Accept edge E0 → READ (E0–E1) → EXEC (E1–E2) → WB (E2–E3) → IDLE.
- `instr_ready` returns high after E3.
- Throughput: one instruction per 4 cycles.
- `alu_a`/`alu_b`/`alu_ctrl` are stable for the whole EXEC cycle; the ALU must settle within one cycle.
- `rf_rd1`/`rf_rd2` are sampled at E1.
- `rf_wa`/`rf_wd`/`br_target` are registered and stable throughout WB.
- `instr_valid` while busy is ignored and not consumed. A held request is accepted on the first IDLE edge.
- Reset released mid-cycle: first accept is no earlier than the first rising edge with `rst_n`=1.

## Test plan
- Reset: assert `rst_n`=0 mid-EXEC → immediately `busy`=0, `instr_ready`=1, `alu_ctrl`=4'hF, `rf_we`=0. No writeback follows after release, and the next instruction completes normally.
- ADDI: `instr`=0xD205, `rf_rd1`=0x0000 → one cycle of `rf_we`=1, `rf_wa`=1, `rf_wd`=0x0005, exactly 3 edges after accept.
- SUB: `instr`=0x1650, R1=0x0010, R2=0x0003 → `alu_ctrl`=4'h1 in EXEC; `rf_wa`=3, `rf_wd`=0x000D.
- BEQ pair at pc=0x0040, offset 0x3E:
  - Equal operands → `br_taken`=1, `br_target`=0x003F.
  - Then unequal operands → `br_taken`=0 (stale-zero check).
- JUMP: `instr`=0xA123, pc=0x8000, `alu` attached → `br_taken`=1, `br_target`=0x0246, `rf_we`=0.
- Illegal plus backpressure: `instr`=0xE000 → `illegal` pulse in WB, no `rf_we`/`br_taken`. `instr_valid` held high throughout → the second instruction is accepted only after WB.

Source files
------------

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multicycle issue controller driving a 16-bit ALU
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    input  logic [15:0] pc,
    output logic        instr_ready,
    output logic [2:0]  rf_ra1,
    output logic [2:0]  rf_ra2,
    input  logic [15:0] rf_rd1,
    input  logic [15:0] rf_rd2,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [15:0] alu_out,
    input  logic        alu_zero,
    output logic        rf_we,
    output logic [2:0]  rf_wa,
    output logic [15:0] rf_wd,
    output logic        br_taken,
    output logic [15:0] br_target,
    output logic        illegal,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [3:0] ALU_NOP = 4'hF;

    state_t      state;
    state_t      state_next;
    logic [15:0] instr_q;
    logic [15:0] pc_q;

    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [15:0] imm6_sext;
    logic [15:0] imm12_zext;
    logic        is_branch;

    assign op         = instr_q[15:12];
    assign rd         = instr_q[11:9];
    assign rs         = instr_q[8:6];
    assign rt         = instr_q[5:3];
    assign imm6_sext  = {{10{instr_q[5]}}, instr_q[5:0]};
    assign imm12_zext = {4'h0, instr_q[11:0]};
    assign is_branch  = (op == 4'hB) || (op == 4'hC);

    // State register; reset drops any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus handshake and register-file read addresses.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        busy        = 1'b1;
        rf_ra1      = 3'd0;
        rf_ra2      = 3'd0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
                // Branches compare rd against rs; everything else reads rs/rt.
                rf_ra1     = is_branch ? rd : rs;
                rf_ra2     = is_branch ? rs : rt;
                state_next = S_EXEC;
            end
            S_EXEC:  state_next = S_WB;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: capture instruction, load ALU operands, sample result, pulse strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= 16'h0;
            pc_q      <= 16'h0;
            alu_a     <= 16'h0;
            alu_b     <= 16'h0;
            alu_ctrl  <= ALU_NOP;
            rf_we     <= 1'b0;
            rf_wa     <= 3'd0;
            rf_wd     <= 16'h0;
            br_taken  <= 1'b0;
            br_target <= 16'h0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        pc_q    <= pc;
                    end
                end
                S_READ: begin
                    if (op <= 4'h9 || is_branch) begin
                        alu_a    <= rf_rd1;
                        alu_b    <= rf_rd2;
                        alu_ctrl <= op;
                    end else if (op == 4'hA) begin
                        alu_a    <= pc_q;
                        alu_b    <= imm12_zext;
                        alu_ctrl <= 4'hA;
                    end else if (op == 4'hD) begin
                        alu_a    <= rf_rd1;
                        alu_b    <= imm6_sext;
                        alu_ctrl <= 4'h0;
                    end
                end
                S_EXEC: begin
                    // ALU returns to its default op so the next compare starts with zero cleared.
                    alu_a     <= 16'h0;
                    alu_b     <= 16'h0;
                    alu_ctrl  <= ALU_NOP;
                    rf_wa     <= rd;
                    rf_wd     <= alu_out;
                    br_target <= (op == 4'hA) ? alu_out : (pc_q + 16'd1 + imm6_sext);
                    rf_we     <= (op <= 4'h9) || (op == 4'hD);
                    br_taken  <= (op == 4'hA) || (is_branch && alu_zero);
                    illegal   <= (op >= 4'hE);
                end
                default: begin
                    rf_we    <= 1'b0;
                    br_taken <= 1'b0;
                    illegal  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        instr_ready;
    logic [2:0]  rf_ra1;
    logic [2:0]  rf_ra2;
    logic [15:0] rf_rd1;
    logic [15:0] rf_rd2;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [15:0] alu_out;
    logic        alu_zero;
    logic        rf_we;
    logic [2:0]  rf_wa;
    logic [15:0] rf_wd;
    logic        br_taken;
    logic [15:0] br_target;
    logic        illegal;
    logic        busy;

    logic [15:0] regs [8];
    int          n_checks;
    int          n_fail;

    alu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc          (pc),
        .instr_ready (instr_ready),
        .rf_ra1      (rf_ra1),
        .rf_ra2      (rf_ra2),
        .rf_rd1      (rf_rd1),
        .rf_rd2      (rf_rd2),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .illegal     (illegal),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational register file reads.
    assign rf_rd1 = regs[rf_ra1];
    assign rf_rd2 = regs[rf_ra2];

    // Reference ALU; op A returns (a+b)<<1, op F is the idle op with zero cleared.
    always_comb begin
        alu_out  = 16'h0;
        alu_zero = 1'b0;
        case (alu_ctrl)
            4'h0: alu_out = alu_a + alu_b;
            4'h1: alu_out = alu_a - alu_b;
            4'h2: alu_out = $signed(alu_a) >>> alu_b[3:0];
            4'h3: alu_out = alu_a >> alu_b[3:0];
            4'h4: alu_out = alu_a << alu_b[3:0];
            4'h5: alu_out = alu_a & alu_b;
            4'h6: alu_out = alu_a | alu_b;
            4'h7: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 16'h1 : 16'h0;
            4'h8: alu_out = ~alu_a;
            4'h9: alu_out = alu_a;
            4'hA: alu_out = (alu_a + alu_b) << 1;
            4'hB: alu_zero = (alu_a == alu_b);
            4'hC: alu_zero = (alu_a != alu_b);
            default: alu_out = 16'h0;
        endcase
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [15:0] i, input logic [15:0] p);
        instr_valid = 1'b1;
        instr       = i;
        pc          = p;
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0;
        pc          = 16'h0;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0;
        regs[1] = 16'h0010;
        regs[2] = 16'h0003;
        regs[3] = 16'h0010;

        #12;
        chk("rst_ready",    {15'h0, instr_ready}, 16'h1);
        chk("rst_busy",     {15'h0, busy},        16'h0);
        chk("rst_alu_ctrl", {12'h0, alu_ctrl},    16'hF);
        chk("rst_rf_we",    {15'h0, rf_we},       16'h0);
        chk("rst_alu_a",    alu_a,                16'h0);
        rst_n = 1'b1;
        tick();

        // ADDI r1 <- r0 + 5
        issue(16'hD205, 16'h0000);
        chk("addi_read_busy", {15'h0, busy},        16'h1);
        chk("addi_read_rdy",  {15'h0, instr_ready}, 16'h0);
        chk("addi_ra1",       {13'h0, rf_ra1},      16'h0);
        tick();
        chk("addi_exec_ctrl", {12'h0, alu_ctrl},    16'h0);
        chk("addi_exec_b",    alu_b,                16'h0005);
        chk("addi_exec_we",   {15'h0, rf_we},       16'h0);
        tick();
        chk("addi_wb_we",     {15'h0, rf_we},       16'h1);
        chk("addi_wb_wa",     {13'h0, rf_wa},       16'h1);
        chk("addi_wb_wd",     rf_wd,                16'h0005);
        chk("addi_wb_ctrl",   {12'h0, alu_ctrl},    16'hF);
        tick();
        chk("addi_done_we",   {15'h0, rf_we},       16'h0);
        chk("addi_done_rdy",  {15'h0, instr_ready}, 16'h1);

        // SUB r3 <- r1 - r2
        issue(16'h1650, 16'h0001);
        chk("sub_ra1", {13'h0, rf_ra1}, 16'h1);
        chk("sub_ra2", {13'h0, rf_ra2}, 16'h2);
        tick();
        chk("sub_ctrl", {12'h0, alu_ctrl}, 16'h1);
        chk("sub_a",    alu_a,             16'h0010);
        chk("sub_b",    alu_b,             16'h0003);
        tick();
        chk("sub_we", {15'h0, rf_we}, 16'h1);
        chk("sub_wa", {13'h0, rf_wa}, 16'h3);
        chk("sub_wd", rf_wd,          16'h000D);
        tick();

        // BEQ r1, r3 (equal), offset -2 at pc 0x40
        issue(16'hB2FE, 16'h0040);
        chk("beq1_ra1", {13'h0, rf_ra1}, 16'h1);
        chk("beq1_ra2", {13'h0, rf_ra2}, 16'h3);
        tick();
        chk("beq1_ctrl", {12'h0, alu_ctrl}, 16'hB);
        tick();
        chk("beq1_taken",  {15'h0, br_taken}, 16'h1);
        chk("beq1_target", br_target,         16'h003F);
        chk("beq1_we",     {15'h0, rf_we},    16'h0);
        tick();
        chk("beq1_taken_clr", {15'h0, br_taken}, 16'h0);

        // BEQ r1, r2 (unequal) right after a taken compare
        issue(16'hB2BE, 16'h0040);
        tick();
        tick();
        chk("beq2_taken", {15'h0, br_taken}, 16'h0);
        chk("beq2_we",    {15'h0, rf_we},    16'h0);
        tick();

        // JUMP from 0x8000, imm12 0x123
        issue(16'hA123, 16'h8000);
        tick();
        chk("jmp_ctrl", {12'h0, alu_ctrl}, 16'hA);
        chk("jmp_a",    alu_a,             16'h8000);
        chk("jmp_b",    alu_b,             16'h0123);
        tick();
        chk("jmp_taken",  {15'h0, br_taken}, 16'h1);
        chk("jmp_target", br_target,         16'h0246);
        chk("jmp_we",     {15'h0, rf_we},    16'h0);
        tick();
        chk("jmp_taken_clr", {15'h0, br_taken}, 16'h0);

        // Illegal op with a second request held high throughout
        instr_valid = 1'b1;
        instr       = 16'hE000;
        pc          = 16'h0010;
        tick();
        instr = 16'h0A50;
        chk("ill_read_rdy", {15'h0, instr_ready}, 16'h0);
        tick();
        chk("ill_exec_ctrl", {12'h0, alu_ctrl},    16'hF);
        chk("ill_exec_a",    alu_a,                16'h0);
        chk("ill_exec_rdy",  {15'h0, instr_ready}, 16'h0);
        tick();
        chk("ill_wb_pulse", {15'h0, illegal},  16'h1);
        chk("ill_wb_we",    {15'h0, rf_we},    16'h0);
        chk("ill_wb_taken", {15'h0, br_taken}, 16'h0);
        chk("ill_wb_busy",  {15'h0, busy},     16'h1);
        tick();
        chk("ill_idle_pulse", {15'h0, illegal},     16'h0);
        chk("ill_idle_rdy",   {15'h0, instr_ready}, 16'h1);
        tick();
        instr_valid = 1'b0;
        chk("held_accept_busy", {15'h0, busy}, 16'h1);
        tick();
        chk("held_exec_ctrl", {12'h0, alu_ctrl}, 16'h0);
        tick();
        chk("held_wb_we", {15'h0, rf_we}, 16'h1);
        chk("held_wb_wa", {13'h0, rf_wa}, 16'h5);
        chk("held_wb_wd", rf_wd,          16'h0013);
        tick();

        // Reset asserted mid-EXEC discards the pending writeback
        issue(16'h0A50, 16'h0020);
        tick();
        chk("rst_pre_ctrl", {12'h0, alu_ctrl}, 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {15'h0, busy},        16'h0);
        chk("rst_mid_rdy",  {15'h0, instr_ready}, 16'h1);
        chk("rst_mid_ctrl", {12'h0, alu_ctrl},    16'hF);
        chk("rst_mid_we",   {15'h0, rf_we},       16'h0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_no_wb", {15'h0, rf_we}, 16'h0);
        end

        // Normal completion after reset
        issue(16'hD205, 16'h0000);
        tick();
        tick();
        chk("post_rst_we", {15'h0, rf_we}, 16'h1);
        chk("post_rst_wa", {13'h0, rf_wa}, 16'h1);
        chk("post_rst_wd", rf_wd,          16'h0005);
        tick();
        chk("post_rst_rdy", {15'h0, instr_ready}, 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
